// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor instruction dispatcher.
// Holds opcode values, instruction-word field positions, FSM state encoding
// and a small opcode classification helper.
package coproc_pkg;

  localparam int unsigned INSTR_W = 29;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned ST_W    = 3;

  // Instruction word layout: [28]=req, [27:24]=opcode, [23:16]=addr, [15:0]=data
  localparam int unsigned REQ_BIT  = 28;
  localparam int unsigned OPC_LSB  = 24;
  localparam int unsigned ADDR_LSB = 16;
  localparam int unsigned DATA_LSB = 0;

  localparam logic [OPC_W-1:0] OP_NOP = 4'd0;
  localparam logic [OPC_W-1:0] OP_WR  = 4'd1;
  localparam logic [OPC_W-1:0] OP_RD  = 4'd2;
  localparam logic [OPC_W-1:0] OP_ADD = 4'd3;
  localparam logic [OPC_W-1:0] OP_SUB = 4'd4;
  localparam logic [OPC_W-1:0] OP_MUL = 4'd5;
  localparam logic [OPC_W-1:0] OP_AND = 4'd6;
  localparam logic [OPC_W-1:0] OP_OR  = 4'd7;
  localparam logic [OPC_W-1:0] OP_XOR = 4'd8;

  localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [ST_W-1:0] ST_DISPATCH = 3'd1;
  localparam logic [ST_W-1:0] ST_RD_WAIT  = 3'd2;
  localparam logic [ST_W-1:0] ST_OP_WAIT  = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE     = 3'd4;

  // Opcodes handed to the arithmetic core
  function automatic logic is_core_op(input logic [OPC_W-1:0] opc);
    return (opc >= OP_ADD) && (opc <= OP_XOR);
  endfunction

endpackage

// File: rtl/coproc_instr_field_latch.sv
// Request edge detection and instruction holding registers.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   instruction    29-bit PIO word from the HPS
//   accept_en      dispatcher is idle and may take a new instruction
//   accept_c       combinational accept strobe (req rising while idle)
//   opcode/addr/data  fields captured on the accept cycle
module coproc_instr_field_latch
  import coproc_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [INSTR_W-1:0] instruction,
  input  logic              accept_en,
  output logic              accept_c,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  logic req;
  logic req_d;

  assign req      = instruction[REQ_BIT];
  assign accept_c = accept_en && req && !req_d;

  // req_d resets high so a req held across reset must drop before it is taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_d  <= 1'b1;
      opcode <= '0;
      addr   <= '0;
      data   <= '0;
    end else begin
      req_d <= req;
      if (accept_c) begin
        opcode <= instruction[OPC_LSB +: OPC_W];
        addr   <= instruction[ADDR_LSB +: ADDR_W];
        data   <= instruction[DATA_LSB +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/coproc_instr_dispatch.sv
// Coprocessor instruction dispatcher.
// Accepts an instruction on the rising edge of req, dispatches it to the
// matrix memory port (WR/RD) or the arithmetic core (opcodes 3..8), and
// reports busy/done/error status plus RD read data back to the HPS.
// mem_rdata is sampled on the MEM_RD_LATENCY-th clock edge after the edge
// that raises mem_rd_en.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   instruction                       PIO word {req, opcode, addr, data}
//   mem_wr_en, mem_rd_en              one-cycle memory strobes
//   mem_addr, mem_wdata, mem_rdata    memory address / write / read data
//   op_start, op_code, op_done        arithmetic core handshake
//   status_busy/done/error            status for the HPS input PIO
//   result_data                       data returned by the last RD
module coproc_instr_dispatch
  import coproc_pkg::*;
#(
  parameter int unsigned MEM_RD_LATENCY = 2,
  parameter int unsigned OP_TIMEOUT     = 1023
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] instruction,
  output logic               mem_wr_en,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               op_start,
  output logic [OPC_W-1:0]   op_code,
  input  logic               op_done,
  output logic               status_busy,
  output logic               status_done,
  output logic               status_error,
  output logic [DATA_W-1:0]  result_data
);

  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(MEM_RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(OP_TIMEOUT - 1);

  logic              req;
  logic              accept_c;
  logic [OPC_W-1:0]  hold_opc;
  logic [ST_W-1:0]   state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              wr_nx, rd_nx, start_nx;
  logic              busy_nx, done_nx, err_nx;
  logic [DATA_W-1:0] result_nx;

  assign req     = instruction[REQ_BIT];
  assign op_code = hold_opc;

  // Holding registers drive the memory address/data and core opcode directly
  coproc_instr_field_latch u_field_latch (
    .clk         (clk),
    .reset_n     (reset_n),
    .instruction (instruction),
    .accept_en   (state == ST_IDLE),
    .accept_c    (accept_c),
    .opcode      (hold_opc),
    .addr        (mem_addr),
    .data        (mem_wdata)
  );

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      mem_wr_en    <= 1'b0;
      mem_rd_en    <= 1'b0;
      op_start     <= 1'b0;
      status_busy  <= 1'b0;
      status_done  <= 1'b0;
      status_error <= 1'b0;
      result_data  <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      mem_wr_en    <= wr_nx;
      mem_rd_en    <= rd_nx;
      op_start     <= start_nx;
      status_busy  <= busy_nx;
      status_done  <= done_nx;
      status_error <= err_nx;
      result_data  <= result_nx;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    wr_nx     = 1'b0;
    rd_nx     = 1'b0;
    start_nx  = 1'b0;
    busy_nx   = status_busy;
    done_nx   = status_done;
    err_nx    = status_error;
    result_nx = result_data;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          busy_nx  = 1'b1;
          err_nx   = 1'b0;
          state_nx = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        cnt_nx = '0;
        if (hold_opc == OP_RD) begin
          rd_nx    = 1'b1;
          state_nx = ST_RD_WAIT;
        end else if (is_core_op(hold_opc)) begin
          start_nx = 1'b1;
          state_nx = ST_OP_WAIT;
        end else begin
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          state_nx = ST_DONE;
          if (hold_opc == OP_WR) begin
            wr_nx = 1'b1;
          end else if (hold_opc != OP_NOP) begin
            err_nx = 1'b1;
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt == RD_LAST) begin
          result_nx = mem_rdata;
          busy_nx   = 1'b0;
          done_nx   = 1'b1;
          state_nx  = ST_DONE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_OP_WAIT: begin
        // op_done in the final timeout cycle still completes cleanly
        if (op_done) begin
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          state_nx = ST_DONE;
        end else if (cnt == TO_LAST) begin
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          err_nx   = 1'b1;
          state_nx = ST_DONE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (!req) begin
          done_nx  = 1'b0;
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule
